// File: rtl/softmax_vec_serializer_if.sv
// ---------------------------------------------------------------------------
// softmax_vec_serializer_if
// Bundles the vector-input and element-output signals of the serializer.
//   valid_in, prob_flat, length_mode : vector push side (upstream -> block)
//   in_ready                         : advisory "has a free entry" flag
//   out_valid/out_ready              : element handshake
//   out_data, out_elem_idx,
//   out_row_idx, out_last            : current element and its position
//   overflow                         : sticky "a vector was dropped" flag
// Modports: master = environment driving the block, slave = the block itself.
// ---------------------------------------------------------------------------
interface softmax_vec_serializer_if #(
    parameter int LANES = 64,
    parameter int W     = 16
);
    logic                 valid_in;
    logic [LANES*W-1:0]   prob_flat;
    logic [1:0]           length_mode;
    logic                 in_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [W-1:0]         out_data;
    logic [5:0]           out_elem_idx;
    logic [1:0]           out_row_idx;
    logic                 out_last;
    logic                 overflow;

    modport master (
        output valid_in, prob_flat, length_mode, out_ready,
        input  in_ready, out_valid, out_data, out_elem_idx, out_row_idx,
               out_last, overflow
    );

    modport slave (
        input  valid_in, prob_flat, length_mode, out_ready,
        output in_ready, out_valid, out_data, out_elem_idx, out_row_idx,
               out_last, overflow
    );
endinterface

// File: rtl/softmax_vec_serializer.sv
// ---------------------------------------------------------------------------
// softmax_vec_serializer
// Captures whole probability vectors into a DEPTH-entry circular buffer and
// streams them out one element per transfer, lane 0 first. Each element is
// tagged with its lane index, its row-segment index and a last-of-segment
// flag derived from the length_mode stored with the vector.
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset (priority over everything)
//   en   : global enable; when low all state holds and pushes are ignored
//   bus  : softmax_vec_serializer_if.slave (push side, element side, flags)
// ---------------------------------------------------------------------------
module softmax_vec_serializer #(
    parameter int LANES = 64,
    parameter int W     = 16,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    softmax_vec_serializer_if.slave  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t             state_reg, state_next;
    logic [PW-1:0]      head_reg, tail_reg;
    logic [CW-1:0]      count_reg, count_next;
    logic [5:0]         idx_reg, idx_next;
    logic               overflow_reg;
    logic               in_ready_reg;

    logic [LANES*W-1:0] vec_mem  [DEPTH];
    logic [1:0]         mode_mem [DEPTH];

    logic               full, push, xfer, pop, accept;
    logic [LANES*W-1:0] head_vec;
    logic [1:0]         head_mode;
    logic [W-1:0]       lane_data [LANES];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full   = (count_reg == CW'(DEPTH));
    assign push   = en && bus.valid_in;
    assign xfer   = (state_reg == STREAM) && en && bus.out_ready;
    assign pop    = xfer && (idx_reg == 6'(LANES - 1));
    // A full buffer can still take a push when the head leaves on this edge.
    assign accept = push && (!full || pop);

    always_comb begin
        count_next = count_reg;
        case ({accept, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // Read-side FSM: looks at count_next so a push into an empty buffer
    // starts streaming on the very next cycle, and a push coinciding with the
    // final pop keeps STREAM without a bubble.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            IDLE: begin
                if (count_next != '0) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (xfer) begin
                    if (pop) begin
                        idx_next = '0;
                        if (count_next == '0) begin
                            state_next = IDLE;
                        end
                    end else begin
                        idx_next = idx_reg + 6'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            idx_reg      <= '0;
            overflow_reg <= 1'b0;
            in_ready_reg <= 1'b1;
        end else if (en) begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            count_reg    <= count_next;
            in_ready_reg <= (count_next < CW'(DEPTH));
            if (pop) begin
                head_reg <= ptr_inc(head_reg);
            end
            if (accept) begin
                tail_reg <= ptr_inc(tail_reg);
            end
            if (push && !accept) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Vector storage carries no reset; entries are only ever read once valid.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            vec_mem[tail_reg]  <= bus.prob_flat;
            mode_mem[tail_reg] <= bus.length_mode;
        end
    end

    assign head_vec  = vec_mem[head_reg];
    assign head_mode = mode_mem[head_reg];

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lane_data[gi] = head_vec[gi*W +: W];
    end

    // Element tags are forced to zero outside STREAM so an idle block shows a
    // clean all-zero output regardless of stale buffer contents.
    always_comb begin
        bus.out_valid    = (state_reg == STREAM) && en;
        bus.out_data     = '0;
        bus.out_elem_idx = '0;
        bus.out_row_idx  = '0;
        bus.out_last     = 1'b0;
        if (state_reg == STREAM) begin
            bus.out_data     = lane_data[idx_reg];
            bus.out_elem_idx = idx_reg;
            case (head_mode)
                2'd0: begin
                    bus.out_row_idx = idx_reg[5:4];
                    bus.out_last    = &idx_reg[3:0];
                end
                2'd1: begin
                    bus.out_row_idx = {1'b0, idx_reg[5]};
                    bus.out_last    = &idx_reg[4:0];
                end
                default: begin
                    bus.out_row_idx = 2'd0;
                    bus.out_last    = &idx_reg;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_reg;
    assign bus.overflow = overflow_reg;

endmodule

// File: tb/tb_softmax_vec_serializer.sv
// ---------------------------------------------------------------------------
// tb_softmax_vec_serializer
// Directed scenarios plus a randomized phase. Expected behaviour comes from a
// queue-level model: a list of pending vectors, a position within the head
// vector, and the sticky drop flag, advanced once per clock.
// ---------------------------------------------------------------------------
module tb_softmax_vec_serializer;
    localparam int LANES = 64;
    localparam int W     = 16;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    logic en;

    softmax_vec_serializer_if #(.LANES(LANES), .W(W)) bus_if ();

    softmax_vec_serializer #(.LANES(LANES), .W(W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [LANES*W-1:0] mq_vec[$];
    logic [1:0]         mq_mode[$];
    int                 m_pos   = 0;
    bit                 m_ovf   = 1'b0;
    bit                 m_inrdy = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LANES*W-1:0] rand_vec();
        logic [LANES*W-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*W +: W] = W'($urandom);
        return v;
    endfunction

    function automatic int seg_len(input logic [1:0] mode);
        return (mode == 2'd0) ? 16 : (mode == 2'd1) ? 32 : 64;
    endfunction

    // One clock: compare current outputs to the model, then advance model.
    task automatic step();
        bit exp_valid, xfer, pop, accept;
        logic [LANES*W-1:0] hv;
        int seg;
        #1;
        exp_valid = en && (mq_vec.size() > 0);
        if (!rst) begin
            chk("out_valid", 32'(bus_if.out_valid), 32'(exp_valid));
            chk("overflow",  32'(bus_if.overflow),  32'(m_ovf));
            chk("in_ready",  32'(bus_if.in_ready),  32'(m_inrdy));
            if (mq_vec.size() > 0) begin
                hv  = mq_vec[0];
                seg = seg_len(mq_mode[0]);
                chk("elem_idx", 32'(bus_if.out_elem_idx), 32'(m_pos));
                chk("row_idx",  32'(bus_if.out_row_idx),  32'(m_pos / seg));
                chk("last",     32'(bus_if.out_last),     32'(((m_pos + 1) % seg) == 0));
                if (exp_valid) chk("data", 32'(bus_if.out_data), 32'(hv[m_pos*W +: W]));
            end
        end
        xfer   = exp_valid && bus_if.out_ready;
        pop    = xfer && (m_pos == LANES - 1);
        accept = en && bus_if.valid_in && ((mq_vec.size() < DEPTH) || pop);
        @(posedge clk);
        if (rst) begin
            mq_vec.delete();
            mq_mode.delete();
            m_pos   = 0;
            m_ovf   = 1'b0;
            m_inrdy = 1'b1;
        end else if (en) begin
            if (bus_if.valid_in && !accept) begin
                m_ovf = 1'b1;
                $display("push dropped mode=%0d", bus_if.length_mode);
            end
            if (xfer) begin
                if (pop) begin
                    $display("vector done mode=%0d", mq_mode[0]);
                    void'(mq_vec.pop_front());
                    void'(mq_mode.pop_front());
                    m_pos = 0;
                end else begin
                    m_pos++;
                end
            end
            if (accept) begin
                mq_vec.push_back(bus_if.prob_flat);
                mq_mode.push_back(bus_if.length_mode);
                $display("push accepted mode=%0d", bus_if.length_mode);
            end
            m_inrdy = (mq_vec.size() < DEPTH);
        end
        #1;
    endtask

    task automatic push_vec(input logic [LANES*W-1:0] v, input logic [1:0] mode);
        bus_if.valid_in    = 1'b1;
        bus_if.prob_flat   = v;
        bus_if.length_mode = mode;
        step();
        bus_if.valid_in    = 1'b0;
    endtask

    task automatic run_to_pos(input int p);
        int guard = 0;
        while (m_pos != p && guard < 200) begin
            step();
            guard++;
        end
        chk("wait_pos_bound", 32'(guard < 200), 32'd1);
    endtask

    task automatic drain();
        int guard = 0;
        while (mq_vec.size() > 0 && guard < 1000) begin
            step();
            guard++;
        end
        chk("drain_bound", 32'(guard < 1000), 32'd1);
        step();
    endtask

    task automatic check_reset();
        #1;
        chk("rst_out_valid", 32'(bus_if.out_valid),    32'd0);
        chk("rst_out_data",  32'(bus_if.out_data),     32'd0);
        chk("rst_elem_idx",  32'(bus_if.out_elem_idx), 32'd0);
        chk("rst_row_idx",   32'(bus_if.out_row_idx),  32'd0);
        chk("rst_last",      32'(bus_if.out_last),     32'd0);
        chk("rst_overflow",  32'(bus_if.overflow),     32'd0);
        chk("rst_in_ready",  32'(bus_if.in_ready),     32'd1);
    endtask

    initial begin
        logic [LANES*W-1:0] ramp;

        rst = 1'b1;
        en  = 1'b1;
        bus_if.valid_in    = 1'b0;
        bus_if.prob_flat   = '0;
        bus_if.length_mode = 2'd0;
        bus_if.out_ready   = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_reset();

        // Mode 0 ramp: 64 back-to-back transfers, data = index
        for (int i = 0; i < LANES; i++) ramp[i*W +: W] = W'(i);
        push_vec(ramp, 2'd0);
        drain();

        // Mode 1 then mode 2, consecutive pushes, no bubble between vectors
        push_vec(rand_vec(), 2'd1);
        push_vec(rand_vec(), 2'd2);
        drain();

        // Backpressure at index 7
        push_vec(rand_vec(), 2'd3);
        run_to_pos(7);
        bus_if.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) step();
        bus_if.out_ready = 1'b1;
        drain();

        // Full buffer plus simultaneous pop: the push must be accepted
        bus_if.out_ready = 1'b0;
        push_vec(rand_vec(), 2'd0);
        push_vec(rand_vec(), 2'd1);
        step();
        bus_if.out_ready = 1'b1;
        run_to_pos(LANES - 1);
        push_vec(rand_vec(), 2'd2);
        drain();

        // Overflow: third back-to-back push while stalled is dropped
        bus_if.out_ready = 1'b0;
        push_vec(rand_vec(), 2'd0);
        push_vec(rand_vec(), 2'd1);
        push_vec(rand_vec(), 2'd2);
        step();
        bus_if.out_ready = 1'b1;
        drain();

        // Enable low mid-stream (pushes ignored), then reset at index 20
        push_vec(rand_vec(), 2'd0);
        run_to_pos(10);
        en = 1'b0;
        bus_if.valid_in  = 1'b1;
        bus_if.prob_flat = rand_vec();
        for (int i = 0; i < 3; i++) step();
        bus_if.valid_in = 1'b0;
        en = 1'b1;
        run_to_pos(20);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset();
        push_vec(rand_vec(), 2'd2);
        drain();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            en                 = ($urandom_range(0, 15) != 0);
            bus_if.out_ready   = ($urandom_range(0, 3) != 0);
            bus_if.valid_in    = ($urandom_range(0, 39) == 0);
            bus_if.prob_flat   = rand_vec();
            bus_if.length_mode = 2'($urandom_range(0, 3));
            step();
        end
        en               = 1'b1;
        bus_if.valid_in  = 1'b0;
        bus_if.out_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
